// File: rtl/dreg_pipe_pkg.sv
// Shared types and helpers for the dreg_pipe registered pipeline.
package dreg_pipe_pkg;

    typedef enum logic {
        SKID_NONE = 1'b0,
        SKID_IN   = 1'b1
    } skid_mode_e;

    // Width of the token counter: holds 0 .. depth+1 (stages plus skid entry).
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/dti.sv
// Valid/ready data transfer interface used by the pipeline ports.
interface dti #(
    parameter int W = 16
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/dreg_pipe_stage.sv
// One bubble-collapsing register stage: accepts whenever empty or when its
// downstream neighbour can accept.
module dreg_pipe_stage #(
    parameter int             W          = 16,
    parameter bit             INIT_VALID = 1'b0,
    parameter logic [W-1:0]   INIT       = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         v_up,
    input  logic [W-1:0] d_up,
    input  logic         rdy_dn,
    output logic         v,
    output logic [W-1:0] d,
    output logic         rdy
);

    assign rdy = !v | rdy_dn;

    // Stage register: load from upstream when ready, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v <= INIT_VALID;
            d <= INIT;
        end else if (rdy) begin
            v <= v_up;
            d <= d_up;
        end
    end

endmodule

// File: rtl/dreg_pipe.sv
// Multi-stage registered valid/ready pipeline with optional input skid entry.
module dreg_pipe
    import dreg_pipe_pkg::*;
#(
    parameter int             DIN        = 16,
    parameter int             DEPTH      = 2,
    parameter logic [DIN-1:0] INIT       = '0,
    parameter int             INIT_VALID = 0,
    parameter int             SKID       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    dti.consumer                    din,
    dti.producer                    dout,
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam skid_mode_e MODE = (SKID != 0) ? SKID_IN : SKID_NONE;
    localparam int         CW   = cnt_w(DEPTH);

    logic             src_v;
    logic [DIN-1:0]   src_d;
    logic             rdy0;
    logic             sv_q;
    logic [DEPTH-1:0] v_all;

    // Each stage lives in its own scope so the ready chain is a series of
    // distinct nets rather than one self-referencing vector.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic           v_up;
        logic           rdy_dn;
        logic           v;
        logic           rdy;
        logic [DIN-1:0] d_up;
        logic [DIN-1:0] d;

        if (i == 0) begin : g_first
            assign v_up = src_v;
            assign d_up = src_d;
        end else begin : g_next
            assign v_up = g_stage[i-1].v;
            assign d_up = g_stage[i-1].d;
        end

        if (i == DEPTH - 1) begin : g_last
            assign rdy_dn = dout.ready;
        end else begin : g_inner
            assign rdy_dn = g_stage[i+1].rdy;
        end

        dreg_pipe_stage #(
            .W          (DIN),
            .INIT_VALID (i >= DEPTH - INIT_VALID),
            .INIT       (INIT)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .v_up   (v_up),
            .d_up   (d_up),
            .rdy_dn (rdy_dn),
            .v      (v),
            .d      (d),
            .rdy    (rdy)
        );

        assign v_all[i] = v;
    end

    assign rdy0       = g_stage[0].rdy;
    assign dout.valid = g_stage[DEPTH-1].v;
    assign dout.data  = g_stage[DEPTH-1].d;

    if (MODE == SKID_IN) begin : g_skid
        logic [DIN-1:0] sd_q;

        // Skid flag: set when an accepted token cannot enter stage 0, cleared
        // once stage 0 takes it.
        always_ff @(posedge clk) begin
            if (!rst) begin
                sv_q <= 1'b0;
            end else if (sv_q) begin
                if (rdy0) sv_q <= 1'b0;
            end else if (din.valid && !rdy0) begin
                sv_q <= 1'b1;
            end
        end

        // Skid data: captured alongside the flag; contents irrelevant when empty.
        always_ff @(posedge clk) begin
            if (!sv_q && din.valid && !rdy0) sd_q <= din.data;
        end

        assign din.ready = !sv_q;
        assign src_v     = sv_q | din.valid;
        assign src_d     = sv_q ? sd_q : din.data;
    end else begin : g_direct
        assign sv_q      = 1'b0;
        assign din.ready = rdy0;
        assign src_v     = din.valid;
        assign src_d     = din.data;
    end

    // Popcount keeps the occupancy consistent with stage state by construction.
    assign count = CW'($countones(v_all)) + CW'(sv_q);

endmodule

// File: doc/dreg_pipe.md
# dreg_pipe

Parametrised multi-stage registered pipeline on the `dti` valid/ready interface.
- Generalises the single decoupling register to `DEPTH` bubble-collapsing stages.
- Each stage can be pre-loaded with `INIT` at reset.
- An optional input skid buffer makes `din.ready` a pure register output, breaking the combinational ready path.
- Used to retime long routes and to balance latency between parallel datapaths without losing throughput.

## Interface
Parameters:
- `DIN`, 16, data width in bits; must match `$size(din.data)`.
- `DEPTH`, 2, number of register stages; must be ≥ 1.
- `INIT`, 0, data value loaded into pre-valid stages at reset.
- `INIT_VALID`, 0, number of output-side stages holding a valid `INIT` token after reset; range 0..`DEPTH`.
- `SKID`, 0, 1 = insert a one-entry skid buffer at the input so `din.ready` is registered.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, **active-low**; sampled on the `clk` rising edge.
- `din`  dti.consumer  `DIN`+2  input stream (`data`, `valid`, `ready`).
- `dout`  dti.producer  `DIN`+2  output stream.
- `count`  out  `$clog2(DEPTH+2)`  number of tokens currently held (all stages plus the skid entry).

## Operation
- **Stages.** Stages are numbered 0 (input side) to `DEPTH-1` (output side).
  - Each stage holds `v[i]` and `d[i]`.
  - `rdy[i] = !v[i] | rdy_dn[i]`, where `rdy_dn[i]` is `rdy[i+1]`, or `dout.ready` for the last stage.
  - When `rdy[i]` is high: `v[i] <= v_up`, `d[i] <= d_up`.
  - When `rdy[i]` is low: the stage holds.
  - Bubbles therefore collapse: a stage is never stalled by an empty stage downstream.
- **Output.** `dout.valid = v[DEPTH-1]`; `dout.data = d[DEPTH-1]`.
- **Input, `SKID=0`.** The upstream of stage 0 is `din`, and `din.ready = rdy[0]`. This is a combinational path from `dout.ready`.
- **Input, `SKID=1`.** The skid buffer is `sv`/`sd`, and `din.ready = !sv`.
  - Upstream of stage 0 is the skid entry when `sv=1`, otherwise `din`.
  - Capture: if `din.valid & din.ready & !rdy[0]`, then `sv <= 1`, `sd <= din.data`.
  - Drain: if `sv & rdy[0]`, then `sv <= 0`.
  - The skid buffer never captures while `sv=1`, because `din.ready` is low then.
- **Data integrity.** Data is never modified, dropped or duplicated, and tokens leave in arrival order.
- **Token count.** `count` equals the number of set `v[i]`, plus `sv`. Its maximum is `DEPTH+SKID`.
- **Reset** (`rst` low at a clock edge):
  - Stages `DEPTH-INIT_VALID` .. `DEPTH-1`: `v=1`, `d=INIT`.
  - All other stages: `v=0`, data unspecified.
  - `sv=0`.
  - `count=INIT_VALID`.
  - Reset overrides any handshake in the same cycle. Tokens in flight are discarded with no partial transfer.
- **Output values after reset:**
  - `dout.valid = (INIT_VALID>0)`.
  - `dout.data = INIT` when `INIT_VALID>0`.
  - `din.ready = 1` whenever `SKID=1` or `INIT_VALID<DEPTH`.
  - Otherwise `din.ready = dout.ready`.

## Timing
- **Latency.** In an empty pipe, a token accepted at edge t is presented on `dout` after edge t+`DEPTH`. The skid buffer adds no latency when empty.
- **Throughput.** One token per cycle sustained whenever `dout.ready` is held high.
- **Full pipe, `dout.ready` low.**
  - `SKID=0`: `din.ready` is low.
  - `SKID=1`: one more token is accepted into the skid buffer, then `din.ready` falls on the next cycle.
- **Full pipe, `dout.ready` high.** Simultaneous input and output transfers are allowed in the same cycle, and `count` is unchanged.
- **Stall recovery, `SKID=1`.** `din.ready` rises the cycle after the skid entry drains into stage 0.
- **Valid stability.** `dout.valid` never falls without a handshake, and `dout.data` is stable while `dout.valid & !dout.ready`.

## Structure
- Package `dreg_pipe_pkg`:
  - Function `cnt_w(depth)` returning `$clog2(depth+2)`.
  - Typedef for the `SKID` mode enum: `SKID_NONE`, `SKID_IN`.
- Sub-module `dreg_pipe_stage`: one valid/data stage with its `rdy` equation.
  - Instantiated `DEPTH` times with a `generate` loop.
  - Takes an `init_valid` parameter per instance.
- The skid buffer and the `count` logic live in the top level.
- `count` is computed as a popcount of the valid bits, not as an up/down counter, so that it is consistent with the stage state by construction.

## Test plan
- **Reset pre-load.** `DEPTH=3`, `INIT=16'h00A5`, `INIT_VALID=2`, `dout.ready=0`, release `rst` → `dout.valid=1`, `dout.data=16'h00A5`, `count=2`, `din.ready=1`. Then raise `dout.ready` → two `00A5` tokens out in back-to-back cycles, then `count=0`.
- **Latency and throughput.** `DEPTH=4`, `SKID=0`, stream 1..100 with `dout.ready=1` → first token after 4 cycles, one token per cycle, values in order, `count` steady at 4.
- **Backpressure, `SKID=1`.** `DEPTH=2`, pipe full, drop `dout.ready` → exactly one more token accepted, `count=3`, then `din.ready=0`. Restore `dout.ready` → `din.ready` returns one cycle after the skid entry drains, with no loss.
- **Bubble collapse.** Send a token, idle 3 cycles, send another, with `dout.ready=0` → both are resident in adjacent output-side stages and `count=2`.
- **Random stress.** Random `din.valid` and `dout.ready` at 50% for 10k cycles, all `DEPTH` in 1..5, `SKID` in 0/1 → scoreboard matches, `count` equals the model, `dout.data` is stable while stalled.
- **Mid-stream reset.** Assert `rst` low while the pipe is full and handshakes are active → all in-flight tokens discarded, post-reset state exactly as specified, and no token emitted in the reset cycle.
